opb_status_bank: RTL and testbench

OPB_STATUS_BANK -- requirements
Module: opb_status_bank

---
 rtl/opb_status_bank.sv | 113 +++++++++++
 tb/tb_opb_status_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_status_bank.sv
// opb_status_bank: OPB slave with per-channel snapshot, sticky-OR and saturating event-count registers.
// Read data is registered into the ack cycle; writes land at the edge that closes the ack cycle.
module opb_status_bank #(
    parameter logic [31:0] C_BASEADDR = 32'h01008100,
    parameter logic [31:0] C_HIGHADDR = 32'h010081FF,
    parameter int          C_NUM_CH   = 4,
    parameter int          C_USER_DW  = 32
) (
    input  logic                            OPB_Clk,
    input  logic                            OPB_Rst,
    input  logic [0:31]                     OPB_ABus,
    input  logic [0:3]                      OPB_BE,
    input  logic [0:31]                     OPB_DBus,
    input  logic                            OPB_RNW,
    input  logic                            OPB_select,
    input  logic                            OPB_seqAddr,
    output logic [0:31]                     Sl_DBus,
    output logic                            Sl_xferAck,
    output logic                            Sl_errAck,
    output logic                            Sl_retry,
    output logic                            Sl_toutSup,
    input  logic [C_NUM_CH*C_USER_DW-1:0]   user_data_in,
    input  logic [C_NUM_CH-1:0]             user_valid
);
    logic [31:0]          w_addr, w_wdata, w_off, w_rdata;
    logic [27:0]          w_blk;
    logic [3:0]           w_sub;
    logic                 w_hit, w_wr, w_wr_ctrl, w_snap_now, w_clr_all, w_unused;
    logic                 r_ack, r_auto;
    logic [31:0]          r_dbus;
    logic [C_USER_DW-1:0] r_live [C_NUM_CH];
    logic [C_USER_DW-1:0] r_snap [C_NUM_CH];
    logic [C_USER_DW-1:0] r_sticky [C_NUM_CH];
    logic [C_USER_DW-1:0] w_ch [C_NUM_CH];
    logic [C_USER_DW-1:0] w_clr [C_NUM_CH];
    logic [C_USER_DW-1:0] w_sticky_nxt [C_NUM_CH];
    logic [31:0]          r_count [C_NUM_CH];
    logic [31:0]          w_count_nxt [C_NUM_CH];

    // Bus vectors are big-endian indexed, so numeric value equals register value.
    assign w_addr     = OPB_ABus;
    assign w_wdata    = OPB_DBus;
    assign w_off      = w_addr - C_BASEADDR;
    assign w_blk      = w_off[31:4];
    assign w_sub      = w_off[3:0];
    assign w_hit      = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
    assign w_wr       = r_ack && w_hit && !OPB_RNW && (OPB_BE == 4'b1111);
    assign w_wr_ctrl  = w_wr && (w_off == 32'd0);
    assign w_snap_now = w_wr_ctrl && w_wdata[0];
    assign w_clr_all  = w_wr_ctrl && w_wdata[1];
    assign w_unused   = &{1'b0, OPB_seqAddr, w_wdata};

    assign Sl_DBus    = r_dbus;
    assign Sl_xferAck = r_ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    genvar g;
    generate
        for (g = 0; g < C_NUM_CH; g++) begin : g_ch
            assign w_ch[g] = user_data_in[g*C_USER_DW +: C_USER_DW];
        end
    endgenerate

    always_comb begin
        w_rdata = (w_off == 32'd0) ? {10'd0, 6'(C_USER_DW), 8'(C_NUM_CH), 5'd0, r_auto, 2'd0} : 32'd0;
        for (int i = 0; i < C_NUM_CH; i++)
            if (w_blk == 28'(i + 1))
                w_rdata = (w_sub == 4'h0) ? 32'(r_snap[i]) :
                          (w_sub == 4'h4) ? 32'(r_sticky[i]) :
                          (w_sub == 4'h8) ? r_count[i] : 32'd0;
    end

    // A clear and a same-cycle valid compose so that the new event always survives.
    always_comb begin
        for (int i = 0; i < C_NUM_CH; i++) begin
            w_clr[i] = w_clr_all ? {C_USER_DW{1'b1}} :
                       (w_wr && w_blk == 28'(i + 1) && w_sub == 4'h4) ? w_wdata[C_USER_DW-1:0] :
                       {C_USER_DW{1'b0}};
            w_sticky_nxt[i] = (r_sticky[i] & ~w_clr[i]) | (user_valid[i] ? w_ch[i] : {C_USER_DW{1'b0}});
            w_count_nxt[i] = (w_clr_all || (w_wr && w_blk == 28'(i + 1) && w_sub == 4'h8)) ? {31'd0, user_valid[i]} :
                             (user_valid[i] && r_count[i] != 32'hFFFF_FFFF) ? r_count[i] + 32'd1 : r_count[i];
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_ack  <= 1'b0;
            r_dbus <= 32'd0;
            r_auto <= 1'b0;
            for (int i = 0; i < C_NUM_CH; i++) begin
                r_live[i]   <= '0;
                r_snap[i]   <= '0;
                r_sticky[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            r_ack  <= w_hit && !r_ack;
            r_dbus <= (w_hit && !r_ack) ? w_rdata : 32'd0;
            if (w_wr_ctrl)
                r_auto <= w_wdata[2];
            for (int i = 0; i < C_NUM_CH; i++) begin
                if (user_valid[i])
                    r_live[i] <= w_ch[i];
                if (r_auto || w_snap_now)
                    r_snap[i] <= r_live[i];
                r_sticky[i] <= w_sticky_nxt[i];
                r_count[i]  <= w_count_nxt[i];
            end
        end
    end
endmodule

// File: tb/tb_opb_status_bank.sv
// tb_opb_status_bank: directed and randomized bus/channel traffic checked against a transaction-level model.
module tb_opb_status_bank;
    localparam logic [31:0] BASE = 32'h01008100;
    localparam logic [31:0] HIGH = 32'h010081FF;
    localparam int          NCH  = 4;
    localparam int          DW   = 32;
    localparam logic [31:0] DMASK = 32'hFFFF_FFFF >> (32 - DW);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [0:31]       abus = '0;
    logic [0:3]        be = '0;
    logic [0:31]       wdat = '0;
    logic              rnw = 1'b1;
    logic              sel = 1'b0;
    logic              seq = 1'b0;
    logic [0:31]       sl_dbus;
    logic              ack, err_ack, retry, tout;
    logic [NCH*DW-1:0] udata = '0;
    logic [NCH-1:0]    uvalid = '0;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_live [NCH];
    logic [31:0] m_snap [NCH];
    logic [31:0] m_sticky [NCH];
    logic [31:0] m_count [NCH];
    logic        m_auto;

    opb_status_bank #(.C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_NUM_CH(NCH), .C_USER_DW(DW)) dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(wdat),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err_ack), .Sl_retry(retry), .Sl_toutSup(tout),
        .user_data_in(udata), .user_valid(uvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_live[i] = 0; m_snap[i] = 0; m_sticky[i] = 0; m_count[i] = 0;
        end
        m_auto = 0;
    endfunction

    function automatic logic in_range(input logic [31:0] a);
        return a >= BASE && a <= HIGH;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off;
        int blk, sub;
        off = a - BASE;
        blk = int'(off >> 4);
        sub = int'(off & 32'hF);
        if (!in_range(a)) return 0;
        if (off == 0) return (32'(DW) << 16) | (32'(NCH) << 8) | (32'(m_auto) << 2);
        if (blk >= 1 && blk <= NCH) begin
            if (sub == 0) return m_snap[blk-1];
            if (sub == 4) return m_sticky[blk-1];
            if (sub == 8) return m_count[blk-1];
        end
        return 0;
    endfunction

    // State change at one clock edge: an optional completing write plus that cycle's channel valids.
    function automatic void model_edge(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] b, input logic [NCH-1:0] v, input logic [NCH*DW-1:0] vd);
        logic [31:0] old_live [NCH];
        logic [31:0] off, vi, clr;
        logic full, snow, clra;
        full = wr && b == 4'hF && in_range(a);
        off  = a - BASE;
        snow = full && off == 0 && d[0];
        clra = full && off == 0 && d[1];
        old_live = m_live;
        for (int i = 0; i < NCH; i++) begin
            vi  = 32'(vd[i*DW +: DW]);
            clr = clra ? DMASK : (full && off == 32'(16*(i+1)+4)) ? (d & DMASK) : 32'd0;
            if (m_auto || snow) m_snap[i] = old_live[i];
            m_sticky[i] = (m_sticky[i] & ~clr) | (v[i] ? vi : 32'd0);
            if (clra || (full && off == 32'(16*(i+1)+8))) m_count[i] = 0;
            if (v[i] && m_count[i] != 32'hFFFF_FFFF) m_count[i] = m_count[i] + 1;
            if (v[i]) m_live[i] = vi;
        end
        if (full && off == 0) m_auto = d[2];
    endfunction

    function automatic logic [NCH*DW-1:0] chd(input int ch, input logic [31:0] val);
        logic [NCH*DW-1:0] r;
        r = '0;
        r[ch*DW +: DW] = val[DW-1:0];
        return r;
    endfunction

    function automatic logic [NCH*DW-1:0] rnd_vd();
        logic [NCH*DW-1:0] r;
        for (int j = 0; j < NCH; j++) r[j*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic cyc(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       input logic [NCH-1:0] v, input logic [NCH*DW-1:0] vd);
        uvalid = v;
        udata  = vd;
        @(posedge clk);
        model_edge(wr, a, d, b, v, vd);
        @(negedge clk);
        uvalid = '0;
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [NCH-1:0] v,
                      input logic [NCH*DW-1:0] vd, output logic [31:0] got);
        logic [31:0] exp;
        logic hit;
        exp = m_read(a);
        hit = in_range(a);
        sel = 1; abus = a; rnw = 1; be = 4'hF;
        cyc(0, a, 0, 4'hF, v, vd);
        got = sl_dbus;
        chk({tag, "_ack"}, 32'(ack), 32'(hit));
        chk({tag, "_data"}, got, hit ? exp : 32'd0);
        sel = 0;
        cyc(0, 0, 0, 0, '0, '0);
        chk({tag, "_ack_end"}, {sl_dbus[0:30], ack}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b, input string tag,
                      input logic [NCH-1:0] v2, input logic [NCH*DW-1:0] vd2);
        sel = 1; abus = a; wdat = d; be = b; rnw = 0;
        cyc(0, a, d, b, '0, '0);
        chk({tag, "_ack"}, 32'(ack), 32'(in_range(a)));
        cyc(1, a, d, b, v2, vd2);
        sel = 0; rnw = 1;
        chk({tag, "_ack_end"}, 32'(ack), 32'd0);
    endtask

    initial begin
        logic [31:0] got, a, d;
        logic [3:0]  b;
        logic [NCH-1:0] v;
        int n;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dbus", sl_dbus, 0);
        rst = 0;

        rd(BASE, "ctrl_reset", '0, '0, got);
        chk("ctrl_value", got, 32'h00200400);

        cyc(0, 0, 0, 0, 4'b0010, chd(1, 32'h1234));
        wr(BASE, 32'h1, 4'hF, "snap_now", '0, '0);
        cyc(0, 0, 0, 0, 4'b0010, chd(1, 32'h5678));
        rd(BASE + 32'h20, "snap1", '0, '0, got);
        chk("snap1_value", got, 32'h00001234);

        cyc(0, 0, 0, 0, 4'b0001, chd(0, 32'h0F));
        cyc(0, 0, 0, 0, 4'b0001, chd(0, 32'hF0));
        wr(BASE + 32'h14, 32'h3C, 4'hF, "sticky0_w1c", '0, '0);
        rd(BASE + 32'h14, "sticky0", '0, '0, got);
        chk("sticky0_value", got, 32'h000000C3);

        dut.r_count[2] <= 32'hFFFF_FFFB;
        m_count[2] = 32'hFFFF_FFFB;
        repeat (3) cyc(0, 0, 0, 0, 4'b0100, '0);
        rd(BASE + 32'h38, "count2_pre", '0, '0, got);
        chk("count2_pre_value", got, 32'hFFFF_FFFE);
        repeat (2) cyc(0, 0, 0, 0, 4'b0100, '0);
        rd(BASE + 32'h38, "count2_sat", '0, '0, got);
        chk("count2_sat_value", got, 32'hFFFF_FFFF);
        wr(BASE + 32'h38, 32'h0, 4'hF, "count2_clr", 4'b0100, '0);
        rd(BASE + 32'h38, "count2_clrv", '0, '0, got);
        chk("count2_clrv_value", got, 32'h1);

        n = 0;
        sel = 1; abus = BASE; rnw = 1; be = 4'hF;
        repeat (6) begin
            cyc(0, 0, 0, 0, '0, '0);
            if (ack) n++;
        end
        sel = 0;
        cyc(0, 0, 0, 0, '0, '0);
        if (ack) n++;
        chk("held_select_acks", 32'(n), 32'd3);

        wr(BASE, 32'h4, 4'b0011, "ctrl_partial_be", '0, '0);
        rd(BASE, "ctrl_after_partial", '0, '0, got);
        chk("ctrl_auto_kept", got, 32'h00200400);
        rd(HIGH + 32'h4, "above_high", '0, '0, got);
        rd(HIGH, "at_high", '0, '0, got);
        rd(BASE - 32'h4, "below_base", '0, '0, got);
        wr(HIGH + 32'h4, 32'h4, 4'hF, "wr_above_high", '0, '0);
        rd(BASE, "ctrl_after_oob", '0, '0, got);

        for (int k = 0; k < 400; k++) begin
            v = NCH'($urandom & $urandom);
            a = BASE + (($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : ($urandom_range(0, NCH*16 + 15) & ~32'h3));
            b = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            d = (a == BASE) ? ($urandom & 32'h7 & (($urandom_range(0, 3) == 0) ? 32'h7 : 32'h5)) : $urandom;
            case ($urandom_range(0, 3))
                0: cyc(0, 0, 0, 0, v, rnd_vd());
                1: wr(a, d, b, "rnd_wr", v, rnd_vd());
                default: rd(a, "rnd_rd", v, rnd_vd(), got);
            endcase
        end

        wr(BASE, 32'h4, 4'hF, "auto_on", '1, rnd_vd());
        cyc(0, 0, 0, 0, '1, rnd_vd());
        cyc(0, 0, 0, 0, '1, rnd_vd());
        sel = 1; abus = BASE + 32'h10; rnw = 1; be = 4'hF;
        #2 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_ack", 32'(ack), 0);
        chk("rst_mid_dbus", sl_dbus, 0);
        sel = 0;
        rst = 0;
        m_reset();
        cyc(0, 0, 0, 0, '0, '0);
        chk("rst_no_late_ack", 32'(ack), 0);
        rd(BASE, "ctrl_post_rst", '0, '0, got);
        chk("ctrl_post_rst_value", got, 32'h00200400);
        for (int i = 0; i < NCH; i++) begin
            rd(BASE + 32'(16*(i+1)), "snap_post_rst", '0, '0, got);
            chk("snap_post_rst_zero", got, 0);
            rd(BASE + 32'(16*(i+1)+4), "sticky_post_rst", '0, '0, got);
            chk("sticky_post_rst_zero", got, 0);
            rd(BASE + 32'(16*(i+1)+8), "count_post_rst", '0, '0, got);
            chk("count_post_rst_zero", got, 0);
        end

        cyc(0, 0, 0, 0, 4'b1000, chd(3, 32'hA5));
        sel = 1; abus = BASE + 32'h44; rnw = 1; be = 4'hF;
        cyc(0, 0, 0, 0, '0, '0);
        chk("pre_async_ack", 32'(ack), 1);
        #1 rst = 1;
        #1;
        chk("async_ack_drop", 32'(ack), 0);
        chk("async_dbus_drop", sl_dbus, 0);
        sel = 0;
        @(negedge clk);
        rst = 0;
        m_reset();
        rd(BASE + 32'h44, "sticky3_post_async", '0, '0, got);
        chk("sticky3_post_async_zero", got, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
